// File: rtl/qtree_stream_loader_pkg.sv
// rtl/qtree_stream_loader_pkg.sv - shared types, tags, states and constructors for the quadtree loader
// Purpose: heap word layouts used by the loader, its pointer stack and its environment.
// Layouts (bit0 is always the valid flag):
//   QTree_Int_t         [66:1] payload, [2:1] constructor tag
//   QNode payload       [18:3] child0 (first), [34:19] child1, [50:35] child2, [66:51] child3
//   Pointer_QTree_Int_t [16:1] heap address
//   Int_t               [32:1] integer value
package qtree_stream_loader_pkg;

    localparam int PTR_W = 16;
    localparam int INT_W = 32;

    typedef logic [66:0]      QTree_Int_t;
    typedef logic [PTR_W:0]   Pointer_QTree_Int_t;
    typedef logic [0:0]       Go_t;
    typedef logic [INT_W:0]   Int_t;
    typedef logic [PTR_W-1:0] addr_t;

    localparam logic [1:0] TAG_EMPTY = 2'd0;
    localparam logic [1:0] TAG_LEAF  = 2'd1;
    localparam logic [1:0] TAG_QNODE = 2'd2;
    localparam logic [1:0] TAG_FULL  = 2'd3;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_WRITE,
        ST_PTR,
        ST_LAUNCH,
        ST_RUN,
        ST_HOLD,
        ST_DONE,
        ST_ERROR
    } state_t;

    // c0 is the first child, taken from the top of the pointer stack
    function automatic QTree_Int_t QNode_Int_dc(addr_t c0, addr_t c1, addr_t c2, addr_t c3);
        return {c3, c2, c1, c0, TAG_QNODE, 1'b1};
    endfunction

    function automatic Pointer_QTree_Int_t Pointer_QTree_Int_dc(addr_t a);
        return {a, 1'b1};
    endfunction

endpackage

// File: rtl/qtree_stream_loader_if.sv
// rtl/qtree_stream_loader_if.sv - handshake bundle between the loader and its stream, heap and circuit
// Purpose: groups every valid/ready channel of the loader.
// Modports: master = loader side, slave = environment side (stream source, heap, circuit, result sink).
interface qtree_stream_loader_if #(
    parameter int NUM_ARGS = 3
);
    import qtree_stream_loader_pkg::*;

    QTree_Int_t         s_tdata;
    logic               s_tlast;
    logic               s_tvalid;
    logic               s_tready;

    QTree_Int_t         wr_d;
    logic               wr_r;

    Pointer_QTree_Int_t ptr_d;
    logic               ptr_r;

    Go_t                go_d;
    logic               go_r;

    Pointer_QTree_Int_t arg_d [NUM_ARGS];
    logic [NUM_ARGS-1:0] arg_r;

    Int_t               res_d;
    logic               res_r;

    logic [31:0]        result_data;
    logic               result_valid;
    logic               result_ready;

    modport master (
        input  s_tdata, s_tlast, s_tvalid,
        output s_tready,
        output wr_d,
        input  wr_r,
        input  ptr_d,
        output ptr_r,
        output go_d,
        input  go_r,
        output arg_d,
        input  arg_r,
        input  res_d,
        output res_r,
        output result_data, result_valid,
        input  result_ready
    );

    modport slave (
        output s_tdata, s_tlast, s_tvalid,
        input  s_tready,
        input  wr_d,
        output wr_r,
        output ptr_d,
        input  ptr_r,
        input  go_d,
        output go_r,
        input  arg_d,
        output arg_r,
        output res_d,
        input  res_r,
        input  result_data, result_valid,
        output result_ready
    );

endinterface

// File: rtl/qtree_ptr_stack.sv
// rtl/qtree_ptr_stack.sv - LIFO of heap pointers with single push, single pop and quad pop
// Purpose: holds addresses of completed subtrees until a QNode or an argument slot consumes them.
// Ports: clk, reset, clear (drop all entries), push/push_data, pop1, pop4,
//        top0..top3 (top0 = most recent), depth, overflow/underflow strobes (combinational).
module qtree_ptr_stack
    import qtree_stream_loader_pkg::*;
#(
    parameter int STACK_DEPTH = 256
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear,
    input  logic                           push,
    input  addr_t                          push_data,
    input  logic                           pop1,
    input  logic                           pop4,
    output addr_t                          top0,
    output addr_t                          top1,
    output addr_t                          top2,
    output addr_t                          top3,
    output logic [$clog2(STACK_DEPTH):0]   depth,
    output logic                           overflow,
    output logic                           underflow
);

    localparam int AW = $clog2(STACK_DEPTH);
    localparam int DW = AW + 1;

    addr_t           mem [STACK_DEPTH];
    logic [AW-1:0]   sp;
    logic            full;
    logic            grow;
    logic            shrink1;

    assign sp   = depth[AW-1:0];
    assign full = (depth == DW'(STACK_DEPTH));

    assign top0 = mem[sp - AW'(1)];
    assign top1 = mem[sp - AW'(2)];
    assign top2 = mem[sp - AW'(3)];
    assign top3 = mem[sp - AW'(4)];

    // push together with pop1 hands the pushed value straight through: depth is unchanged
    assign overflow  = push && !pop1 && full;
    assign underflow = (pop4 && (depth < DW'(4))) || (pop1 && !push && (depth == '0));
    assign grow      = push && !pop1 && !full;
    assign shrink1   = pop1 && !push && (depth != '0);

    always_ff @(posedge clk) begin
        if (grow) begin
            mem[sp] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            depth <= '0;
        end else if (pop4 && !underflow) begin
            depth <= depth - DW'(4);
        end else if (grow) begin
            depth <= depth + DW'(1);
        end else if (shrink1) begin
            depth <= depth - DW'(1);
        end
    end

endmodule

// File: rtl/qtree_stream_loader.sv
// rtl/qtree_stream_loader.sv - streams quadtree arguments into the heap and launches the circuit
// Purpose: accepts serialized quadtree nodes, writes each to the heap, stacks returned pointers,
//          builds QNodes from the top four pointers, then issues go/arg tokens and captures the result.
// Ports: clk, reset (sync, active high), bus (qtree_stream_loader_if.master: s_t*, wr_*, ptr_*,
//        go_*, arg_*, res_*, result_*), err ([0] stack overflow, [1] stack underflow, sticky),
//        busy (state is neither LOAD nor DONE).
module qtree_stream_loader
    import qtree_stream_loader_pkg::*;
#(
    parameter int NUM_ARGS    = 3,
    parameter int STACK_DEPTH = 256,
    parameter int MULTI_RUN   = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    qtree_stream_loader_if.master   bus,
    output logic [1:0]              err,
    output logic                    busy
);

    state_t                 state;
    state_t                 state_next;

    logic [3:0]             k;
    logic                   tlast_q;
    logic [65:0]            wr_payload;
    logic                   go_vld;
    logic [NUM_ARGS-1:0]    arg_vld;
    addr_t                  arg_addr [NUM_ARGS];
    logic [31:0]            result_q;
    logic [1:0]             err_q;

    logic                   wr_valid;
    logic                   accept;
    logic                   pop4;
    logic                   ptr_take;
    logic                   pop1;
    logic                   stk_clear;
    logic                   k_last;
    logic                   launch_left;
    QTree_Int_t             qnode_word;

    addr_t                  top0, top1, top2, top3;
    logic [$clog2(STACK_DEPTH):0] stk_depth;
    logic                   stk_overflow;
    logic                   stk_underflow;

    logic                   unused_tdata_bit0;
    assign unused_tdata_bit0 = bus.s_tdata[0];

    assign accept    = (state == ST_LOAD) && bus.s_tvalid;
    assign pop4      = accept && (bus.s_tdata[2:1] == TAG_QNODE);
    assign ptr_take  = (state == ST_PTR) && bus.ptr_d[0];
    // a tree's final pointer goes to the next argument slot instead of staying stacked
    assign pop1      = ptr_take && tlast_q;
    assign stk_clear = (state == ST_HOLD) && bus.result_ready && (MULTI_RUN != 0);
    assign k_last    = (k == 4'(NUM_ARGS - 1));
    assign launch_left = (go_vld && !bus.go_r) || ((arg_vld & ~bus.arg_r) != '0);
    assign qnode_word  = QNode_Int_dc(top0, top1, top2, top3);

    qtree_ptr_stack #(
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .clear     (stk_clear),
        .push      (ptr_take),
        .push_data (bus.ptr_d[PTR_W:1]),
        .pop1      (pop1),
        .pop4      (pop4),
        .top0      (top0),
        .top1      (top1),
        .top2      (top2),
        .top3      (top3),
        .depth     (stk_depth),
        .overflow  (stk_overflow),
        .underflow (stk_underflow)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next       = state;
        bus.s_tready     = 1'b0;
        bus.ptr_r        = 1'b0;
        bus.res_r        = 1'b0;
        bus.result_valid = 1'b0;
        wr_valid         = 1'b0;
        case (state)
            ST_LOAD: begin
                bus.s_tready = 1'b1;
                if (bus.s_tvalid) begin
                    state_next = stk_underflow ? ST_ERROR : ST_WRITE;
                end
            end
            ST_WRITE: begin
                wr_valid = 1'b1;
                if (bus.wr_r) begin
                    state_next = ST_PTR;
                end
            end
            ST_PTR: begin
                bus.ptr_r = 1'b1;
                if (bus.ptr_d[0]) begin
                    if (stk_overflow) begin
                        state_next = ST_ERROR;
                    end else if (tlast_q && k_last) begin
                        state_next = ST_LAUNCH;
                    end else begin
                        state_next = ST_LOAD;
                    end
                end
            end
            ST_LAUNCH: begin
                if (!launch_left) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                bus.res_r = 1'b1;
                if (bus.res_d[0]) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                bus.result_valid = 1'b1;
                if (bus.result_ready) begin
                    state_next = (MULTI_RUN != 0) ? ST_LOAD : ST_DONE;
                end
            end
            default: begin
                state_next = state;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            k          <= '0;
            tlast_q    <= 1'b0;
            wr_payload <= '0;
            go_vld     <= 1'b0;
            arg_vld    <= '0;
            result_q   <= '0;
            err_q      <= '0;
            for (int i = 0; i < NUM_ARGS; i++) begin
                arg_addr[i] <= '0;
            end
        end else begin
            if (accept) begin
                tlast_q    <= bus.s_tlast;
                wr_payload <= pop4 ? qnode_word[66:1] : bus.s_tdata[66:1];
            end
            if (stk_overflow) begin
                err_q[0] <= 1'b1;
            end
            if (stk_underflow) begin
                err_q[1] <= 1'b1;
            end
            if (pop1) begin
                for (int i = 0; i < NUM_ARGS; i++) begin
                    if (k == 4'(i)) begin
                        arg_addr[i] <= bus.ptr_d[PTR_W:1];
                    end
                end
                k <= k + 4'd1;
                if (k_last) begin
                    go_vld  <= 1'b1;
                    arg_vld <= '1;
                end
            end
            if (state == ST_LAUNCH) begin
                go_vld  <= go_vld && !bus.go_r;
                arg_vld <= arg_vld & ~bus.arg_r;
            end
            if ((state == ST_RUN) && bus.res_d[0]) begin
                result_q <= bus.res_d[INT_W:1];
            end
            if (stk_clear) begin
                k <= '0;
            end
        end
    end

    assign bus.wr_d        = {wr_payload, wr_valid};
    assign bus.go_d        = go_vld;
    assign bus.result_data = result_q;
    assign err             = err_q;
    assign busy            = !((state == ST_LOAD) || (state == ST_DONE));

    for (genvar g = 0; g < NUM_ARGS; g++) begin : g_arg
        assign bus.arg_d[g] = Pointer_QTree_Int_dc(arg_addr[g]) & {{PTR_W{1'b1}}, arg_vld[g]};
    end

endmodule

// File: tb/tb_qtree_stream_loader.sv
// tb/tb_qtree_stream_loader.sv - directed self-checking bench for qtree_stream_loader
module tb_qtree_stream_loader;
    import qtree_stream_loader_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset;
    logic                sel;
    QTree_Int_t          s_tdata;
    logic                s_tlast, s_tvalid, wr_r, go_r, result_ready;
    Pointer_QTree_Int_t  ptr_d;
    logic [2:0]          arg_r;
    Int_t                res_d;
    logic [1:0]          err0, err1;
    logic                busy0, busy1;
    logic [15:0]         next_addr;

    int checks = 0;
    int errors = 0;

    qtree_stream_loader_if #(.NUM_ARGS(3)) b0 ();
    qtree_stream_loader_if #(.NUM_ARGS(1)) b1 ();

    assign b0.s_tdata = s_tdata;       assign b1.s_tdata = s_tdata;
    assign b0.s_tlast = s_tlast;       assign b1.s_tlast = s_tlast;
    assign b0.s_tvalid = s_tvalid;     assign b1.s_tvalid = s_tvalid;
    assign b0.wr_r = wr_r;             assign b1.wr_r = wr_r;
    assign b0.ptr_d = ptr_d;           assign b1.ptr_d = ptr_d;
    assign b0.go_r = go_r;             assign b1.go_r = go_r;
    assign b0.arg_r = arg_r;           assign b1.arg_r = arg_r[0:0];
    assign b0.res_d = res_d;           assign b1.res_d = res_d;
    assign b0.result_ready = result_ready;
    assign b1.result_ready = result_ready;

    qtree_stream_loader #(.NUM_ARGS(3), .STACK_DEPTH(256), .MULTI_RUN(0)) u0 (
        .clk(clk), .reset(reset), .bus(b0), .err(err0), .busy(busy0));
    qtree_stream_loader #(.NUM_ARGS(1), .STACK_DEPTH(4), .MULTI_RUN(1)) u1 (
        .clk(clk), .reset(reset), .bus(b1), .err(err1), .busy(busy1));

    QTree_Int_t         cur_wr;
    Go_t                cur_go;
    Pointer_QTree_Int_t cur_arg0;
    logic               cur_tready, cur_ptr_r, cur_res_r, cur_rvalid, cur_busy;
    logic [31:0]        cur_rdata;
    logic [1:0]         cur_err;

    always_comb begin
        if (sel) begin
            cur_wr = b1.wr_d; cur_go = b1.go_d; cur_arg0 = b1.arg_d[0];
            cur_tready = b1.s_tready; cur_ptr_r = b1.ptr_r; cur_res_r = b1.res_r;
            cur_rvalid = b1.result_valid; cur_rdata = b1.result_data;
            cur_err = err1; cur_busy = busy1;
        end else begin
            cur_wr = b0.wr_d; cur_go = b0.go_d; cur_arg0 = b0.arg_d[0];
            cur_tready = b0.s_tready; cur_ptr_r = b0.ptr_r; cur_res_r = b0.res_r;
            cur_rvalid = b0.result_valid; cur_rdata = b0.result_data;
            cur_err = err0; cur_busy = busy0;
        end
    end

    typedef struct {
        logic [63:0] body;
        logic [1:0]  tag;
        logic        last;
        logic [15:0] exp_arg;
        QTree_Int_t  exp_wr;
        logic        exp_tready;
        logic        exp_busy;
    } vec_t;

    vec_t vt [3];

    task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0;
        wr_r = 1'b1; go_r = 1'b1; arg_r = 3'b111;
        res_d = '0; result_ready = 1'b0;
        next_addr = 16'h0010;
        ptr_d = {next_addr, 1'b1};
        step();
        reset = 1'b0;
    endtask

    // drives one beat through accept, heap write and pointer return
    task automatic send_beat(input logic [63:0] body, input logic [1:0] tag, input logic last,
                             output QTree_Int_t wr_seen);
        int n;
        s_tdata = {body, tag, 1'b0};
        s_tlast = last;
        s_tvalid = 1'b1;
        ptr_d = {next_addr, 1'b1};
        n = 0;
        while (!cur_tready && n < 20) begin step(); n++; end
        step();
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        wr_seen = cur_wr;
        n = 0;
        while (!cur_ptr_r && n < 20) begin step(); n++; end
        check("ptr_handshake", cur_ptr_r, 1'b1);
        step();
        next_addr = next_addr + 16'h0010;
        ptr_d = {next_addr, 1'b1};
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        QTree_Int_t w;
        logic ok;

        vt[0] = '{64'h0123_4567_89ab_cdef, 2'd1, 1'b1, 16'h0010,
                  {64'h0123_4567_89ab_cdef, 2'd1, 1'b1}, 1'b1, 1'b0};
        vt[1] = '{64'hffff_0000_a5a5_5a5a, 2'd0, 1'b1, 16'h0020,
                  {64'hffff_0000_a5a5_5a5a, 2'd0, 1'b1}, 1'b1, 1'b0};
        vt[2] = '{64'h0000_0000_0000_002a, 2'd3, 1'b1, 16'h0030,
                  {64'h0000_0000_0000_002a, 2'd3, 1'b1}, 1'b0, 1'b1};

        // reset state
        sel = 1'b0;
        do_reset();
        check("rst_tready", cur_tready, 1'b1);
        check("rst_wr_valid", cur_wr[0], 1'b0);
        check("rst_ptr_r", cur_ptr_r, 1'b0);
        check("rst_go", cur_go, 1'b0);
        check("rst_arg0_valid", cur_arg0[0], 1'b0);
        check("rst_res_r", cur_res_r, 1'b0);
        check("rst_rdata", cur_rdata, 32'd0);
        check("rst_rvalid", cur_rvalid, 1'b0);
        check("rst_err", cur_err, 2'b00);
        check("rst_busy", cur_busy, 1'b0);

        // three single-leaf trees, all sinks zero-wait
        for (int i = 0; i < 3; i++) begin
            send_beat(vt[i].body, vt[i].tag, vt[i].last, w);
            check($sformatf("vec%0d_wr_d", i), w, vt[i].exp_wr);
            check($sformatf("vec%0d_tready", i), cur_tready, vt[i].exp_tready);
            check($sformatf("vec%0d_busy", i), cur_busy, vt[i].exp_busy);
        end
        check("launch_go", cur_go, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("launch_arg%0d", i), b0.arg_d[i], {vt[i].exp_arg, 1'b1});
        end
        step();
        check("run_res_r", cur_res_r, 1'b1);
        check("run_go_dropped", cur_go, 1'b0);
        res_d = {32'd42, 1'b1};
        step();
        res_d = '0;
        check("hold_rvalid", cur_rvalid, 1'b1);
        check("hold_rdata", cur_rdata, 32'd42);
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        check("done_busy", cur_busy, 1'b0);
        check("done_tready", cur_tready, 1'b0);
        check("done_rdata_kept", cur_rdata, 32'd42);
        check("done_res_r", cur_res_r, 1'b0);

        // arg_r[1] held low for 10 cycles in LAUNCH
        do_reset();
        arg_r = 3'b101;
        for (int i = 0; i < 3; i++) send_beat(64'h1, 2'd1, 1'b1, w);
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (b0.arg_d[1] !== {16'h0020, 1'b1} || cur_res_r !== 1'b0) ok = 1'b0;
            step();
        end
        check("arg1_stable", ok, 1'b1);
        check("arg0_delivered", b0.arg_d[0][0], 1'b0);
        check("go_delivered", cur_go, 1'b0);
        arg_r = 3'b111;
        step();
        check("run_after_arg1", cur_res_r, 1'b1);
        check("arg1_dropped", b0.arg_d[1][0], 1'b0);

        // QNode on a two-deep stack underflows
        do_reset();
        send_beat(64'h5, 2'd1, 1'b0, w);
        send_beat(64'h6, 2'd1, 1'b0, w);
        s_tdata = {64'h0, TAG_QNODE, 1'b0};
        s_tvalid = 1'b1;
        step();
        check("uf_err", cur_err, 2'b10);
        check("uf_busy", cur_busy, 1'b1);
        check("uf_wr_valid", cur_wr[0], 1'b0);
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (cur_tready !== 1'b0) ok = 1'b0;
            step();
        end
        s_tvalid = 1'b0;
        check("uf_tready_low", ok, 1'b1);

        // four leaves then a QNode with tlast (NUM_ARGS=1, STACK_DEPTH=4)
        sel = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) send_beat(64'h7, 2'd1, 1'b0, w);
        check("qn_depth4_err", cur_err, 2'b00);
        send_beat(64'h0, TAG_QNODE, 1'b1, w);
        check("qn_wr_d", w, {16'h0010, 16'h0020, 16'h0030, 16'h0040, 2'b10, 1'b1});
        check("qn_arg0", cur_arg0, {16'h0050, 1'b1});
        check("qn_go", cur_go, 1'b1);
        check("qn_depth", u1.stk_depth, 3'd0);

        // fifth push into a four-entry stack overflows
        do_reset();
        for (int i = 0; i < 4; i++) send_beat(64'h8, 2'd0, 1'b0, w);
        check("ov_pre_err", cur_err, 2'b00);
        check("ov_pre_tready", cur_tready, 1'b1);
        send_beat(64'h9, 2'd3, 1'b0, w);
        check("ov_err", cur_err, 2'b01);
        check("ov_tready", cur_tready, 1'b0);
        check("ov_busy", cur_busy, 1'b1);

        // multi-run: first run completes, second load interrupted by reset
        do_reset();
        send_beat(64'ha, 2'd1, 1'b1, w);
        check("mr1_arg0", cur_arg0, {16'h0010, 1'b1});
        step();
        res_d = {32'd7, 1'b1};
        step();
        res_d = '0;
        check("mr1_rdata", cur_rdata, 32'd7);
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        check("mr1_back_to_load", cur_tready, 1'b1);
        check("mr1_busy", cur_busy, 1'b0);
        check("mr1_rvalid", cur_rvalid, 1'b0);
        check("mr1_rdata_kept", cur_rdata, 32'd7);
        s_tdata = {64'hb, 2'd1, 1'b0};
        s_tlast = 1'b1;
        s_tvalid = 1'b1;
        step();
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        check("mr2_wr_valid", cur_wr[0], 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mr_rst_wr_valid", cur_wr[0], 1'b0);
        check("mr_rst_rdata", cur_rdata, 32'd0);
        check("mr_rst_rvalid", cur_rvalid, 1'b0);
        check("mr_rst_tready", cur_tready, 1'b1);
        check("mr_rst_busy", cur_busy, 1'b0);
        check("mr_rst_go", cur_go, 1'b0);
        check("mr_rst_arg0", cur_arg0[0], 1'b0);
        check("mr_rst_ptr_r", cur_ptr_r, 1'b0);
        check("mr_rst_depth", u1.stk_depth, 3'd0);
        send_beat(64'hc, 2'd1, 1'b1, w);
        check("mr3_arg0", cur_arg0, {16'h0020, 1'b1});
        check("mr3_go", cur_go, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/qtree_stream_loader.md
QTREE_STREAM_LOADER -- requirements
Module: qtree_stream_loader

Interface
REQ-001 NUM_ARGS, default 3, number of tree arguments loaded per run, legal range 1..8.
REQ-002 STACK_DEPTH, default 256, pointer-stack entries, power of two.
REQ-003 MULTI_RUN, default 0; 1 = return to loading after result handshake.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 s_tdata  input  QTree_Int_t  stream node; [2:1] constructor tag, [66:1] payload, bit0 ignored.
REQ-007 s_tlast  input  1  last node of current argument tree.
REQ-008 s_tvalid / s_tready  input / output  1 each  AXI-stream handshake.
REQ-009 wr_d / wr_r  output QTree_Int_t / input 1  heap write channel; bit0 = valid.
REQ-010 ptr_d / ptr_r  input Pointer_QTree_Int_t / output 1  heap-returned address; bit0 = valid.
REQ-011 go_d / go_r  output Go_t / input 1  start token.
REQ-012 arg_d[NUM_ARGS] / arg_r[NUM_ARGS]  output Pointer_QTree_Int_t / input 1  argument pointers.
REQ-013 res_d / res_r  input Int_t / output 1  circuit result; bit0 = valid.
REQ-014 result_data  output  32  captured result; result_valid output 1; result_ready input 1.
REQ-015 err  output  2  sticky: [0] stack overflow, [1] stack underflow; busy output 1 = state not LOAD/DONE.

Function
REQ-016 States: LOAD, WRITE, PTR, LAUNCH, RUN, HOLD, DONE, ERROR.
REQ-017 LOAD: s_tready=1 only here; one beat accepted per visit, then WRITE.
REQ-018 Tags 0, 1, 3: wr_d = {payload, 1}.
REQ-019 Tag 2: wr_d = QNode from top four stack pointers, top = first child; pop four; depth<4 sets err[1], enters ERROR.
REQ-020 WRITE: wr_d held stable with valid=1 until wr_r=1, then PTR.
REQ-021 PTR: ptr_r=1; on ptr_d[0]=1 push pointer; push at depth==STACK_DEPTH sets err[0], enters ERROR.
REQ-022 After push, if latched tlast=1: pop top into arg slot k, k+1; k==NUM_ARGS then LAUNCH, else LOAD; tlast=0 then LOAD.
REQ-023 Minimum per-beat cost 3 cycles: accept t, wr valid t+1, push t+2 with zero-wait sinks.
REQ-024 LAUNCH: go_d and every arg_d valid together; each drops valid on own ready; leave for RUN once all delivered, same cycle allowed.
REQ-025 RUN: res_r=1; capture res_d[32:1]... full Int_t into result_data on res_d[0]=1, then HOLD.
REQ-026 HOLD: result_valid=1 until result_ready=1; then MULTI_RUN ? LOAD with k=0, depth=0 : DONE.
REQ-027 result_data retains last value after handshake until next capture.
REQ-028 DONE and ERROR absorbing until reset: all valid bits 0, s_tready 0, res_r 0.
REQ-029 Simultaneous pop-4 and push never occur same cycle; pop-to-arg and push in same cycle net zero depth change.

Reset
REQ-030 reset=1 at any edge: state LOAD, k 0, depth 0, err 0, all *_d valid bits 0, ptr_r/res_r 0, result_data 0, result_valid 0.
REQ-031 Reset mid-run discards stack and loaded arguments; no partial go/arg token survives.

Structure
REQ-032 Shared package: QTree_Int_t, Pointer_QTree_Int_t, Go_t, Int_t, QNode_Int_dc, Pointer_QTree_Int_dc, tag constants.
REQ-033 Sub-module qtree_ptr_stack(STACK_DEPTH): push, pop1, pop4, top0..top3, depth, overflow/underflow strobes.

Verification
REQ-034 Three single-leaf trees, tlast each, ptr 0x10/0x20/0x30 -> arg_d 0x10/0x20/0x30 with go same cycle; res 42 -> result_data 42.
REQ-035 Four leaves then tag-2 beat with tlast, NUM_ARGS=1 -> wr_d carries children ptrs top-first; arg_d = QNode ptr; depth 0.
REQ-036 Tag-2 beat with depth 2 -> err=2'b10, ERROR; s_tready stays 0.
REQ-037 STACK_DEPTH=4, five leaves without tlast -> err=2'b01 on fifth push.
REQ-038 arg_r[1] held low 10 cycles in LAUNCH -> arg_d[1] stable; RUN entered cycle after arg_r[1] rises.
REQ-039 MULTI_RUN=1, two back-to-back runs, reset asserted mid-second load -> all outputs reset values next cycle.
